// File: rtl/vx_gpu_pkg.sv
// vx_gpu_pkg: shared defaults and the response entry layout for the memory responder
package vx_gpu_pkg;
  localparam int DEF_DATA_SIZE = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_TAG_WIDTH = 8;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_RSP_DEPTH = 4;
  typedef struct packed {
    logic [8*DEF_DATA_SIZE-1:0] data;
    logic [DEF_TAG_WIDTH-1:0]   tag;
  } rsp_entry_t;
endpackage

// File: rtl/vx_fifo_queue.sv
// vx_fifo_queue: circular response queue of DEPTH entries.
//   clk/reset (async, active-low), push/din write an entry, pop consumes the head,
//   dout is the head entry (stable until popped), empty flags no entries.
//   The caller guarantees no push while full.
module vx_fifo_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;
  assign empty  = cnt_q == '0;
  assign do_pop = pop & ~empty;
  assign dout   = store_q[rd_ptr_q];
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = do_pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    cnt_d    = (push && !do_pop) ? cnt_q + 1'b1 : ((!push && do_pop) ? cnt_q - 1'b1 : cnt_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: byte-writable word memory with a fixed-latency read pipeline and
// an in-order, credit-limited response queue.
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_rw/req_addr/req_byteen/req_data/req_tag : request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_tag                            : read responses
//   busy : reads in flight or queued
module vx_mem_responder
  import vx_gpu_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_SIZE-1:0]   req_byteen,
  input  logic [8*DATA_SIZE-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [8*DATA_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic                   busy
);
  localparam int DW = 8 * DATA_SIZE;
  localparam int QW = DW + TAG_WIDTH;
  localparam int PW = $clog2(RSP_DEPTH + 1);
  localparam logic [PW-1:0] PMAX = PW'(RSP_DEPTH);
  logic [DW-1:0] mem_q [2**ADDR_WIDTH];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DW-1:0] dat_q [LATENCY];
  logic [DW-1:0] dat_d [LATENCY];
  logic [TAG_WIDTH-1:0] tag_q [LATENCY];
  logic [TAG_WIDTH-1:0] tag_d [LATENCY];
  logic [PW-1:0] pend_q, pend_d;
  logic [QW-1:0] q_dout;
  logic req_fire, wr_fire, rd_fire, rsp_fire, q_empty;
  // The pending count includes reads still in the pipeline, so a credit is
  // taken at issue and every accepted read is guaranteed a queue slot.
  assign req_ready = reset & (pend_q < PMAX);
  assign req_fire  = req_valid & req_ready;
  assign wr_fire   = req_fire & req_rw;
  assign rd_fire   = req_fire & ~req_rw;
  assign rsp_valid = reset & ~q_empty;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign busy      = reset & (pend_q != '0);
  assign {rsp_data, rsp_tag} = q_dout;
  always_comb begin
    vld_d[0] = rd_fire;
    dat_d[0] = mem_q[req_addr];
    tag_d[0] = req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    pend_d = (rd_fire && !rsp_fire) ? pend_q + 1'b1 : ((!rd_fire && rsp_fire) ? pend_q - 1'b1 : pend_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      pend_q <= '0;
    end else begin
      vld_q  <= vld_d;
      pend_q <= pend_d;
    end
  end
  // Payload registers and the array carry no reset; only valids qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      dat_q[i] <= dat_d[i];
      tag_q[i] <= tag_d[i];
    end
    if (wr_fire)
      for (int b = 0; b < DATA_SIZE; b++)
        if (req_byteen[b]) mem_q[req_addr][8*b +: 8] <= req_data[8*b +: 8];
  end
  vx_fifo_queue #(
    .WIDTH (QW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_q (
    .clk   (clk),
    .reset (reset),
    .push  (vld_q[LATENCY-1]),
    .pop   (rsp_fire),
    .din   ({dat_q[LATENCY-1], tag_q[LATENCY-1]}),
    .dout  (q_dout),
    .empty (q_empty)
  );
endmodule
